// File: rtl/sprite_ram_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sprite_ram_writer
// Purpose  : Write side of the sprite pixel store. The host streams packed
//            32-bit words (8 colour codes each) into a selected sprite slot.
//            Each word is unpacked and written one pixel per cycle into
//            on-chip RAM. A renderer read port returns the colour code
//            addressed by (n_sprite, line, pixel) with one cycle latency.
//
// Ports    : clk, reset                - clock, synchronous active-high reset
//            start, start_id           - begin loading a sprite slot
//            wr_valid, wr_data         - packed pixel word from the host
//            wr_ready                  - word accepted this cycle when valid
//            busy, done, err           - load status / pulses
//            checksum                  - pixel sum of last completed load
//            n_sprite, line, pixel     - renderer read address
//            color_code                - registered read data
//
// Options  : SPRITE_WR_CHECKSUM_EN     - when defined, accumulate the written
//                                        pixels and publish the sum on
//                                        checksum; otherwise checksum is 0.
//
// Revision : 1.0 - initial release
// ============================================================================
module sprite_ram_writer #(
    parameter int N_SPRITES = 26,
    parameter int PIX_W     = 4,
    parameter int SPR_PIX   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       start_id,
    input  logic             wr_valid,
    input  logic [31:0]      wr_data,
    output logic             wr_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      checksum,
    input  logic [5:0]       n_sprite,
    input  logic [9:0]       line,
    input  logic [5:0]       pixel,
    output logic [PIX_W-1:0] color_code
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int         c_idx_w  = $clog2(SPR_PIX);
    localparam int         c_depth  = N_SPRITES * SPR_PIX;
    localparam int         c_aw     = $clog2(c_depth);
    localparam int         c_nib    = 32 / PIX_W;
    localparam int         c_sub_w  = $clog2(c_nib);
    localparam logic [5:0] c_id_lim = 6'(N_SPRITES);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_UNPACK = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [5:0]         r_id;
    logic [c_idx_w-1:0] r_idx;
    logic [c_sub_w-1:0] r_sub;
    logic [31:0]        r_word;
    logic               r_err;

    logic [PIX_W-1:0]   r_mem [0:c_depth-1];

    logic               w_id_ok;
    logic               w_start_ok;
    logic               w_last_nib;
    logic [c_idx_w-1:0] w_idx_nxt;
    logic               w_wrap;
    logic [PIX_W-1:0]   w_wr_nib;
    logic               w_we;
    logic [c_aw-1:0]    w_waddr;
    logic               w_rd_ok;
    logic [c_aw-1:0]    w_raddr;
    logic               w_unused;

    assign w_id_ok    = (start_id < c_id_lim);
    assign w_start_ok = start && w_id_ok;
    assign w_last_nib = (r_sub == c_sub_w'(c_nib - 1));
    assign w_idx_nxt  = r_idx + 1'b1;
    // The last pixel of a sprite is index SPR_PIX-1; the increment wrapping
    // to zero marks the end of the load.
    assign w_wrap     = (w_idx_nxt == '0);
    // Word is shifted down after every write, so the current pixel is
    // always in the low nibble.
    assign w_wr_nib   = r_word[PIX_W-1:0];
    assign w_we       = (r_state == S_UNPACK);
    // Slot ids are below N_SPRITES, so the dropped top id bit is always 0.
    assign w_waddr    = c_aw'({r_id, r_idx});

    // Upper line/pixel bits are outside the 32x32 sprite and are ignored.
    assign w_unused   = &{1'b0, line[9:5], pixel[5]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        wr_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
                if (wr_valid) begin
                    w_state_nxt = S_UNPACK;
                end
            end
            S_UNPACK: begin
                busy = 1'b1;
                if (w_last_nib) begin
                    w_state_nxt = w_wrap ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load datapath: slot id, pixel index, nibble counter, word buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id   <= '0;
            r_idx  <= '0;
            r_sub  <= '0;
            r_word <= '0;
            r_err  <= 1'b0;
        end else begin
            // A bad id is only reported when the block could have taken
            // the start; starts during a load are silently dropped.
            r_err <= (r_state == S_IDLE) && start && !w_id_ok;

            if ((r_state == S_IDLE) && w_start_ok) begin
                r_id  <= start_id;
                r_idx <= '0;
                r_sub <= '0;
            end

            if ((r_state == S_LOAD) && wr_valid) begin
                r_word <= wr_data;
                r_sub  <= '0;
            end

            if (r_state == S_UNPACK) begin
                r_word <= r_word >> PIX_W;
                r_idx  <= w_idx_nxt;
                r_sub  <= r_sub + 1'b1;
            end
        end
    end

    assign err = r_err;

    // ------------------------------------------------------------------
    // Pixel RAM write port (contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wr_nib;
        end
    end

    // ------------------------------------------------------------------
    // Renderer read port. Slot 0 and out-of-range slots render as
    // transparent. A same-cycle write to the read address returns the
    // previous contents.
    // ------------------------------------------------------------------
    assign w_rd_ok = (n_sprite != 6'd0) && (n_sprite < c_id_lim);
    assign w_raddr = c_aw'({n_sprite, line[4:0], pixel[4:0]});

    always_ff @(posedge clk) begin
        if (reset) begin
            color_code <= '0;
        end else if (w_rd_ok) begin
            color_code <= r_mem[w_raddr];
        end else begin
            color_code <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Optional load checksum
    // ------------------------------------------------------------------
`ifdef SPRITE_WR_CHECKSUM_EN
    logic [15:0] r_acc;
    logic [15:0] r_checksum;
    logic [15:0] w_nib_ext;

    assign w_nib_ext = {{(16-PIX_W){1'b0}}, w_wr_nib};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_checksum <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_start_ok) begin
                r_acc <= '0;
            end else if (r_state == S_UNPACK) begin
                r_acc <= r_acc + w_nib_ext;
            end

            // Fold in the final pixel directly so the sum is visible
            // during the done cycle.
            if ((r_state == S_UNPACK) && w_last_nib && w_wrap) begin
                r_checksum <= r_acc + w_nib_ext;
            end
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_ram_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sprite_ram_writer
// Purpose  : Self-checking bench for sprite_ram_writer. Keeps a flat pixel
//            array as the reference store, loads sprites with fixed and
//            random words, and checks status pulses, load timing, checksum
//            and renderer reads against that store.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_ram_writer;

    localparam int NS = 26;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  start_id;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] checksum;
    logic [5:0]  n_sprite;
    logic [9:0]  line;
    logic [5:0]  pixel;
    logic [3:0]  color_code;

    sprite_ram_writer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_id   (start_id),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum),
        .n_sprite   (n_sprite),
        .line       (line),
        .pixel      (pixel),
        .color_code (color_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          last_t0;
    logic [3:0]  cc_log [int];
    logic [3:0]  ref_mem [0:NS*1024-1];
    logic [31:0] words [0:127];
    int          loaded_ids [$];

    typedef struct {
        int         s;
        int         l;
        int         p;
        logic [3:0] exp;
    } rd_vec_t;

    rd_vec_t vec [0:10];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cc_log[cyc] = color_code;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fill_const(input logic [31:0] v);
        for (int i = 0; i < 128; i++) words[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 128; i++) words[i] = $urandom();
    endtask

    // Read through the renderer port and compare with the reference store.
    task automatic rd_model(input int s, input int l, input int p, input string nm);
        logic [3:0] e;
        int         a;
        a = s * 1024 + (l % 32) * 32 + (p % 32);
        if (s == 0 || s >= NS) e = 4'd0;
        else                   e = ref_mem[a];
        n_sprite = 6'(s);
        line     = 10'(l);
        pixel    = 6'(p);
        tick();
        check(nm, color_code, e);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_ready"}, wr_ready, 0);
        check({nm, "_busy"},  busy,     0);
        check({nm, "_done"},  done,     0);
        check({nm, "_err"},   err,      0);
    endtask

    // Start a load of `nwords` words into slot `id`. A full load (128 words)
    // waits for done and checks timing and checksum. Stalls the host for
    // `stall_len` cycles while the block is ready for word `stall_at`.
    task automatic load(input int id, input int nwords, input int stall_at, input int stall_len);
        int          t;
        int          t0;
        int          extra;
        logic [15:0] sum;
        logic [31:0] wv;
        t0    = 0;
        sum   = 16'd0;
        extra = 0;
        start    = 1'b1;
        start_id = 6'(id);
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        for (int w = 0; w < nwords; w++) begin
            t = 0;
            while (!wr_ready && t < 20) begin
                tick();
                t++;
            end
            if (!wr_ready) begin
                check("ready_timeout", wr_ready, 1);
                return;
            end
            if (w == stall_at) begin
                extra = stall_len;
                for (int s = 0; s < stall_len; s++) begin
                    start    = (s == 2);
                    start_id = 6'd40;
                    tick();
                    start = 1'b0;
                    check("stall_ready", wr_ready, 1);
                    check("stall_busy", busy, 1);
                    if (s == 2) check("busy_start_no_err", err, 0);
                end
            end
            wv       = words[w];
            wr_valid = 1'b1;
            wr_data  = wv;
            tick();
            wr_valid = 1'b0;
            wr_data  = $urandom();
            if (w == 0) t0 = cyc;
            for (int k = 0; k < 8; k++) begin
                ref_mem[id * 1024 + w * 8 + k] = wv[4*k +: 4];
                sum = sum + 16'(wv[4*k +: 4]);
            end
        end
        last_t0 = t0;
        if (nwords < 128) begin
            repeat (8) tick();
            return;
        end
        t = 0;
        while (!done && t < 40) begin
            tick();
            t++;
        end
        check("done_pulse", done, 1);
        check("load_cycles", cyc - t0, 1151 + extra);
        check("done_busy", busy, 1);
        tick();
        check("done_single", done, 0);
        check("idle_busy", busy, 0);
`ifdef SPRITE_WR_CHECKSUM_EN
        check("checksum", checksum, sum);
`else
        check("checksum_off", checksum, 0);
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        // Read-back table used after slots 18 (pattern 76543210) and 0 load.
        vec[0]  = '{18,   0,  5, 4'd5};
        vec[1]  = '{18,  31, 31, 4'd7};
        vec[2]  = '{18,   0,  0, 4'd0};
        vec[3]  = '{18,  17, 12, 4'd4};
        vec[4]  = '{18, 995,  6, 4'd6};
        vec[5]  = '{18,   2, 34, 4'd2};
        vec[6]  = '{ 0,   0,  5, 4'd0};
        vec[7]  = '{ 0,  31, 31, 4'd0};
        vec[8]  = '{26,   0,  5, 4'd0};
        vec[9]  = '{63,  31, 31, 4'd0};
        vec[10] = '{30,   1,  1, 4'd0};

        n_cmp    = 0;
        n_bad    = 0;
        cyc      = 0;
        last_t0  = 0;
        reset    = 1'b1;
        start    = 1'b0;
        start_id = 6'd0;
        wr_valid = 1'b0;
        wr_data  = 32'd0;
        n_sprite = 6'd0;
        line     = 10'd0;
        pixel    = 6'd0;

        repeat (3) tick();
        check_idle_outputs("reset");
        check("reset_color", color_code, 0);
        check("reset_checksum", checksum, 0);
        reset = 1'b0;
        tick();

        rd_model(0, 0, 0, "rd_slot0_empty");
        rd_model(40, 5, 5, "rd_bad_slot_empty");

        // Rejected starts: out-of-range ids.
        start = 1'b1; start_id = 6'd30; tick(); start = 1'b0;
        check("err30_pulse", err, 1);
        check("err30_busy", busy, 0);
        check("err30_ready", wr_ready, 0);
        tick();
        check("err30_single", err, 0);
        check("err30_busy2", busy, 0);
        check("err30_ready2", wr_ready, 0);
        start = 1'b1; start_id = 6'd26; tick(); start = 1'b0;
        check("err26_pulse", err, 1);
        check("err26_busy", busy, 0);
        tick();

        // Fixed-pattern loads and table-driven reads.
        fill_const(32'h76543210);
        load(18, 128, 1000, 0);
`ifdef SPRITE_WR_CHECKSUM_EN
        check("checksum_3584", checksum, 16'd3584);
`endif
        loaded_ids.push_back(18);
        fill_const(32'hFFFFFFFF);
        load(0, 128, 1000, 0);
        for (int i = 0; i < 11; i++) begin
            n_sprite = 6'(vec[i].s);
            line     = 10'(vec[i].l);
            pixel    = 6'(vec[i].p);
            tick();
            check($sformatf("table_rd%0d", i), color_code, vec[i].exp);
        end

        // Host stall mid-load, with a start attempt while busy.
        fill_rand();
        load(12, 128, 60, 20);
        loaded_ids.push_back(12);
        for (int i = 0; i < 8; i++)
            rd_model(12, $urandom_range(31), $urandom_range(31), "stall_rd");

        // Same-address read during write returns old data.
        fill_const(32'h22222222);
        load(5, 128, 1000, 0);
        n_sprite = 6'd5; line = 10'd3; pixel = 6'd3;
        fill_const(32'h22222222);
        words[12] = 32'h22229222;
        load(5, 128, 1000, 0);
        check("rw_old_data", cc_log[last_t0 + 112], 4'd2);
        check("rw_new_data", cc_log[last_t0 + 113], 4'd9);
        rd_model(5, 3, 3, "rw_readback");
        loaded_ids.push_back(5);

        // Reset part way through a reload: earlier pixels new, rest old.
        fill_rand();
        load(7, 128, 1000, 0);
        fill_rand();
        load(7, 40, 1000, 0);
        check("partial_busy", busy, 1);
        reset = 1'b1;
        tick();
        check_idle_outputs("midreset");
        check("midreset_color", color_code, 0);
        check("midreset_checksum", checksum, 0);
        reset = 1'b0;
        tick();
        check("postreset_busy", busy, 0);
        check("postreset_ready", wr_ready, 0);
        rd_model(7, 0, 0, "reset_new_first");
        rd_model(7, 9, 31, "reset_new_last");
        rd_model(7, 10, 0, "reset_old_first");
        rd_model(7, 31, 31, "reset_old_last");
        loaded_ids.push_back(7);

        // Highest valid slot and random slots with random data.
        fill_rand();
        load(25, 128, 1000, 0);
        loaded_ids.push_back(25);
        for (int r = 0; r < 2; r++) begin
            int id;
            id = 1 + int'($urandom_range(24));
            fill_rand();
            load(id, 128, 1000, 0);
            loaded_ids.push_back(id);
        end
        for (int i = 0; i < 48; i++) begin
            int s;
            s = loaded_ids[$urandom_range(loaded_ids.size() - 1)];
            rd_model(s, $urandom_range(1023), $urandom_range(63), "rand_rd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
